// File: rtl/counter_updown_param.sv
// Parametrised up/down modulo counter with enable prescaler, clamped load, wrap/saturate and sticky overflow.
// out/ovf update one edge after a tick or load; tick, tc and carry are same-cycle combinational.
module counter_updown_param #(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sat_mode,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] out,
   output logic             tick,
   output logic             tc,
   output logic             carry,
   output logic             ovf
);

   localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

   logic [WIDTH-1:0] r_cnt;
   logic [PW-1:0]    r_pre;
   logic             r_ovf;

   logic             w_at_max;
   logic             w_at_zero;
   logic             w_tc;
   logic             w_tick;
   logic [WIDTH-1:0] w_load_val;
   logic [WIDTH-1:0] w_next;

   assign w_at_max   = (r_cnt == MAX_VAL);
   assign w_at_zero  = (r_cnt == '0);
   assign w_tc       = up ? w_at_max : w_at_zero;
   assign w_tick     = en & ~load & (r_pre == PRE_LAST) & rst;
   // Extra MSB lets MODULUS = 2^WIDTH compare without overflow.
   assign w_load_val = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

   always_comb begin
      w_next = r_cnt;
      if (w_tc) begin
         if (!sat_mode) w_next = up ? '0 : MAX_VAL;
      end else begin
         w_next = up ? (r_cnt + 1'b1) : (r_cnt - 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
         r_pre <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (load) begin
            r_cnt <= w_load_val;
            r_pre <= '0;
         end else if (en) begin
            r_pre <= (r_pre == PRE_LAST) ? '0 : (r_pre + 1'b1);
            if (w_tick) r_cnt <= w_next;
         end
         // A bound-crossing step beats a concurrent clear.
         if (w_tick && w_tc) r_ovf <= 1'b1;
         else if (clr_ovf)   r_ovf <= 1'b0;
      end
   end

   assign out   = r_cnt;
   assign tick  = w_tick;
   assign tc    = w_tc;
   assign carry = w_tick & w_tc;
   assign ovf   = r_ovf;

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed bench for counter_updown_param: default, prescaled, loaded/saturating, reset-mid-prescale and cascaded instances.
module tb_counter_updown_param;

   logic       clk = 1'b0;
   logic       rst, en, up, load, sat_mode, clr_ovf;
   logic [3:0] load_val;

   logic [3:0] a_out, b_out, c_out, d_out, lo_out, hi_out;
   logic a_tick, a_tc, a_carry, a_ovf;
   logic b_tick, b_tc, b_carry, b_ovf;
   logic c_tick, c_tc, c_carry, c_ovf;
   logic d_tick, d_tc, d_carry, d_ovf;
   logic lo_tick, lo_tc, lo_carry, lo_ovf;
   logic hi_tick, hi_tc, hi_carry, hi_ovf;

   int passes = 0;
   int total  = 0;
   int ccount;

   always #5 clk = ~clk;

   counter_updown_param #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_a (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .sat_mode(sat_mode), .clr_ovf(clr_ovf), .out(a_out), .tick(a_tick),
      .tc(a_tc), .carry(a_carry), .ovf(a_ovf));

   counter_updown_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_b (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .sat_mode(sat_mode), .clr_ovf(clr_ovf), .out(b_out), .tick(b_tick),
      .tc(b_tc), .carry(b_carry), .ovf(b_ovf));

   counter_updown_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_c (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .sat_mode(sat_mode), .clr_ovf(clr_ovf), .out(c_out), .tick(c_tick),
      .tc(c_tc), .carry(c_carry), .ovf(c_ovf));

   counter_updown_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) u_d (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .sat_mode(sat_mode), .clr_ovf(clr_ovf), .out(d_out), .tick(d_tick),
      .tc(d_tc), .carry(d_carry), .ovf(d_ovf));

   counter_updown_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_lo (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .sat_mode(sat_mode), .clr_ovf(clr_ovf), .out(lo_out), .tick(lo_tick),
      .tc(lo_tc), .carry(lo_carry), .ovf(lo_ovf));

   counter_updown_param #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_hi (
      .clk(clk), .rst(rst), .en(lo_carry), .up(up), .load(load), .load_val(load_val),
      .sat_mode(sat_mode), .clr_ovf(clr_ovf), .out(hi_out), .tick(hi_tick),
      .tc(hi_tc), .carry(hi_carry), .ovf(hi_ovf));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one rising edge, then settle so outputs are sampled away from it.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
      sat_mode = 1'b0; clr_ovf = 1'b0;
      edge1();
      rst = 1'b1;
      #1;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
      sat_mode = 1'b0; clr_ovf = 1'b0;
      edge1();
      edge1();
      chk("rst_a_out", a_out, 0);
      chk("rst_a_ovf", a_ovf, 0);
      chk("rst_d_out", d_out, 0);
      chk("rst_a_tick", a_tick, 0);

      // Test 1: default counter runs 0..15, 0..3 with one carry at 15.
      rst = 1'b1; en = 1'b1; up = 1'b1;
      #1;
      ccount = 0;
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("t1_out_%0d", i), a_out, i % 16);
         chk($sformatf("t1_carry_%0d", i), a_carry, (i % 16 == 15) ? 1 : 0);
         ccount += int'(a_carry);
         edge1();
      end
      chk("t1_carry_count", ccount, 1);
      chk("t1_ovf", a_ovf, 1);

      // Test 2: prescale 3, modulus 10; tick on every third enabled cycle.
      do_reset();
      en = 1'b1;
      #1;
      for (int n = 1; n <= 30; n++) begin
         chk($sformatf("t2_tick_%0d", n), b_tick, (n % 3 == 0) ? 1 : 0);
         chk($sformatf("t2_out_%0d", n), b_out, ((n - 1) / 3) % 10);
         edge1();
      end
      chk("t2_out_end", b_out, 0);
      chk("t2_ovf_end", b_ovf, 1);

      // Test 3: saturating down-count from a loaded 2.
      do_reset();
      sat_mode = 1'b1; up = 1'b0; load = 1'b1; load_val = 4'd2;
      edge1();
      load = 1'b0; en = 1'b1;
      #1;
      chk("t3_out_2", c_out, 2);
      chk("t3_tc_2", c_tc, 0);
      edge1();
      chk("t3_out_1", c_out, 1);
      edge1();
      chk("t3_out_0", c_out, 0);
      chk("t3_tc_0", c_tc, 1);
      chk("t3_ovf_pre", c_ovf, 0);
      edge1();
      chk("t3_out_hold1", c_out, 0);
      chk("t3_ovf_set", c_ovf, 1);
      edge1();
      chk("t3_out_hold2", c_out, 0);
      en = 1'b0; clr_ovf = 1'b1;
      edge1();
      chk("t3_ovf_clr", c_ovf, 0);
      en = 1'b1;
      edge1();
      chk("t3_ovf_set_wins", c_ovf, 1);
      chk("t3_out_hold3", c_out, 0);
      clr_ovf = 1'b0; en = 1'b0;

      // Test 4: clamped load and load-over-tick priority.
      sat_mode = 1'b0; up = 1'b1; load = 1'b1; load_val = 4'd13;
      edge1();
      chk("t4_clamp13", c_out, 9);
      chk("t4_ovf_kept", c_ovf, 1);
      load_val = 4'd10;
      edge1();
      chk("t4_clamp10", c_out, 9);
      load_val = 4'd4; en = 1'b1;
      #1;
      chk("t4_tick_blocked", c_tick, 0);
      edge1();
      chk("t4_load_wins", c_out, 4);
      load = 1'b0;
      edge1();
      chk("t4_step_after", c_out, 5);

      // Test 5: reset in the middle of a prescale period at out=5.
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 22; i++) edge1();
      chk("t5_out_5", d_out, 5);
      rst = 1'b0;
      edge1();
      chk("t5_rst_out", d_out, 0);
      chk("t5_rst_ovf", d_ovf, 0);
      rst = 1'b1;
      #1;
      for (int n = 1; n <= 4; n++) begin
         chk($sformatf("t5_tick_%0d", n), d_tick, (n == 4) ? 1 : 0);
         chk($sformatf("t5_out_%0d", n), d_out, 0);
         edge1();
      end
      chk("t5_first_step", d_out, 1);

      // Test 6: two-digit decimal cascade tracks cycle count mod 100.
      do_reset();
      en = 1'b1;
      #1;
      ccount = 0;
      for (int i = 0; i < 100; i++) begin
         chk($sformatf("t6_val_%0d", i), 32'(hi_out) * 10 + 32'(lo_out), i);
         ccount += int'(lo_carry);
         edge1();
      end
      chk("t6_lo_wraps", ccount, 10);
      chk("t6_hi_end", hi_out, 0);
      chk("t6_lo_end", lo_out, 0);
      for (int i = 0; i < 37; i++) edge1();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         edge1();
         chk($sformatf("t6_frozen_%0d", i), 32'(hi_out) * 10 + 32'(lo_out), 37);
      end
      en = 1'b1;
      edge1();
      chk("t6_resume", 32'(hi_out) * 10 + 32'(lo_out), 38);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/counter_updown_param.md
Name: counter_updown_param

Overview:
Parametrised up/down modulo counter, successor to the fixed 4-bit free-running counter. Adds:
- generic width and modulus
- an enable prescaler
- synchronous load
- direction control
- wrap/saturate mode
- terminal-count and carry outputs for cascading
- a sticky overflow flag

Used as a timebase, event counter or cascaded stage in datapath/control experiments.

Parameters:
WIDTH, 4, counter width in bits.
MODULUS, 16, count range is 0..MODULUS-1. Legal range is 2..2^WIDTH.
PRESCALE, 1, number of enabled cycles per count step. Must be >=1. Internal prescaler width is clog2(PRESCALE), minimum 1 bit.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-low.
en  input  1  count enable; advances the prescaler.
up  input  1  direction: 1 = up, 0 = down.
load  input  1  synchronous load of load_val.
load_val  input  WIDTH  load value.
sat_mode  input  1  1 = saturate at bound, 0 = wrap.
clr_ovf  input  1  clears the sticky overflow flag.
out  output  WIDTH  registered count.
tick  output  1  combinational: a count step occurs this cycle.
tc  output  1  combinational terminal count.
carry  output  1  combinational tick & tc; drives en of the next cascaded stage.
ovf  output  1  registered sticky overflow/underflow flag.

Behaviour:
- Reset: rst==0 at a rising edge sets out=0, prescaler=0, ovf=0. Reset overrides all other inputs. Reset asserted mid-count or mid-prescale clears everything on that edge, with no partial step.
- Priority per edge: reset > load > count step.
- Load:
  - load==1 sets out=load_val, or out=MODULUS-1 if load_val>=MODULUS (clamp).
  - Prescaler is cleared; ovf is unaffected.
  - Load wins over a simultaneous tick; no step occurs that cycle.
- Prescaler:
  - When en==1 and load==0, pre_cnt increments modulo PRESCALE.
  - When en==0, pre_cnt and out hold.
- tick = en & ~load & (pre_cnt==PRESCALE-1) & rst. With PRESCALE=1, tick equals en & ~load & rst.
- Step on tick, up==1:
  - out<MODULUS-1: out+1.
  - out==MODULUS-1: wrap to 0 (sat_mode=0) or hold at MODULUS-1 (sat_mode=1). ovf is set in both cases.
- Step on tick, up==0:
  - out>0: out-1.
  - out==0: wrap to MODULUS-1 (sat_mode=0) or hold at 0 (sat_mode=1). ovf is set in both cases.
- tc: (up & out==MODULUS-1) | (~up & out==0). It is valid whenever out is stable, independent of en.
- Direction or sat_mode changes apply on the next step. A change never resets the prescaler.
- ovf:
  - Set on any bound-crossing step; held until clr_ovf==1 or reset.
  - Simultaneous set and clr_ovf: set wins, so ovf=1.
- Arithmetic is unsigned, and out never leaves 0..MODULUS-1. When MODULUS=2^WIDTH, the wrap is the natural binary rollover.
- Latency: out changes one edge after the qualifying tick or load. tick, tc and carry are same-cycle combinational.

Test Plan:
1. Defaults (W=4, M=16, P=1), rst=0 for 2 cycles, then rst=1, en=1, up=1 for 20 cycles:
   - out runs 0..15, 0..3.
   - carry pulses exactly once at out=15.
   - ovf=1 after the wrap.
2. W=4, M=10, P=3, en=1, up=1 from 0:
   - out increments every 3rd cycle.
   - tick is high on cycles 3, 6, 9, ...
   - After 30 cycles out=0 (wrapped once) and ovf=1.
3. M=10, sat_mode=1, up=0, load load_val=2, then en=1:
   - out goes 2, 1, 0, 0, 0 and holds at 0.
   - ovf sets on the first blocked step.
   - clr_ovf=1 with no concurrent step clears it; clr_ovf concurrent with a blocked step leaves ovf=1.
4. M=10, load with load_val=13 → out=9 (clamped). load asserted on the same cycle as tick → out=load_val and no step occurs.
5. M=10, P=4, counting up:
   - Pull rst low mid-prescale at out=5: the next edge gives out=0, ovf=0, prescaler=0.
   - Release rst: the first step requires 4 fresh enabled cycles.
6. Two instances (M=10) cascaded via carry→en with P=1, run 100 cycles from reset:
   - Low digit wraps 10 times; high digit reaches 0 after 9.
   - Combined value tracks cycle count mod 100.
   - Toggling en=0 for 5 cycles freezes both stages.
